// File: rtl/gpio_cfg_pkg.sv
// gpio_cfg_pkg: register word offsets, PINCFG field layout and ACK states for gpio_cfg_regs
package gpio_cfg_pkg;
  localparam int FLD_W = 2;
  localparam int MOD_LSB = 0;
  localparam int SEL_LSB = 2;
  localparam logic [5:0] W_IRQEN = 6'h18;
  localparam logic [5:0] W_IRQPOL = 6'h19;
  localparam logic [5:0] W_IRQSTAT = 6'h1A;
  localparam logic [5:0] W_PINSTAT = 6'h1B;
  typedef enum logic {ST_IDLE, ST_ACK} ack_st_e;
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction
endpackage

// File: rtl/gpio_cfg_regs_sync2.sv
// sync2: two-flop synchronizer for asynchronous pad inputs
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] m_q, s_q;
  always_ff @(posedge clk_i)
    if (rst_i) {s_q, m_q} <= '0;
    else {s_q, m_q} <= {m_q, d_i};
  assign q_o = s_q;
endmodule

// File: rtl/gpio_cfg_regs.sv
// gpio_cfg_regs: Wishbone-classic register bank driving the GPIO pin-mux controls
module gpio_cfg_regs
  import gpio_cfg_pkg::*;
#(
  parameter int NPINS = 24,
  parameter logic [7:0] BASE_ADR = 8'h00
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               WB_CYC,
  input  logic               WB_STB,
  input  logic               WB_WE,
  input  logic [3:0]         WB_SEL,
  input  logic [7:0]         WB_ADR,
  input  logic [31:0]        WB_DAT_W,
  output logic [31:0]        WB_DAT_R,
  output logic               WB_ACK,
  output logic [2*NPINS-1:0] MOD,
  output logic [2*NPINS-1:0] SEL,
  output logic [NPINS-1:0]   IRQEN,
  output logic [NPINS-1:0]   IRQPOL,
  output logic [NPINS-1:0]   IRQRES,
  input  logic [NPINS-1:0]   INTR,
  input  logic [NPINS-1:0]   PIN_IN,
  output logic               IRQ
);
  localparam logic [5:0] NP = 6'(NPINS);
  ack_st_e st_q;
  logic [2*NPINS-1:0] mod_q, mod_d, sel_q, sel_d;
  logic [NPINS-1:0] irqen_q, irqen_d, irqpol_q, irqpol_d, irqres_q, pin_s;
  logic [31:0] dat_q, rdata, msk, pc;
  logic irq_q, req, wr, pin, unused_ok;
  logic [5:0] word;
  logic [6:0] pidx;
  sync2 #(.W(NPINS)) u_sync (.clk_i(CLK), .rst_i(RST), .d_i(PIN_IN), .q_o(pin_s));
  assign WB_ACK = st_q == ST_ACK;
  assign WB_DAT_R = dat_q;
  assign MOD = mod_q;
  assign SEL = sel_q;
  assign IRQEN = irqen_q;
  assign IRQPOL = irqpol_q;
  assign IRQRES = irqres_q;
  assign IRQ = irq_q;
  assign unused_ok = ^{WB_ADR[1:0], WB_DAT_W, msk};
  always_comb begin
    req = WB_CYC & WB_STB & ~WB_ACK;
    wr = req & WB_WE;
    word = WB_ADR[7:2] - BASE_ADR[7:2];
    pin = word < NP;
    pidx = {word, 1'b0};
    msk = lane_mask(WB_SEL);
    pc = '0;
    pc[MOD_LSB +: FLD_W] = mod_q[pidx +: FLD_W];
    pc[SEL_LSB +: FLD_W] = sel_q[pidx +: FLD_W];
    rdata = pin ? pc
          : word == W_IRQEN ? 32'(irqen_q)
          : word == W_IRQPOL ? 32'(irqpol_q)
          : word == W_IRQSTAT ? 32'(INTR)
          : word == W_PINSTAT ? 32'(pin_s) : '0;
    mod_d = mod_q;
    sel_d = sel_q;
    if (wr && pin && WB_SEL[0]) begin
      mod_d[pidx +: FLD_W] = WB_DAT_W[MOD_LSB +: FLD_W];
      sel_d[pidx +: FLD_W] = WB_DAT_W[SEL_LSB +: FLD_W];
    end
    irqen_d = wr && word == W_IRQEN
            ? (irqen_q & ~msk[NPINS-1:0]) | (WB_DAT_W[NPINS-1:0] & msk[NPINS-1:0]) : irqen_q;
    irqpol_d = wr && word == W_IRQPOL
             ? (irqpol_q & ~msk[NPINS-1:0]) | (WB_DAT_W[NPINS-1:0] & msk[NPINS-1:0]) : irqpol_q;
  end
  // IRQRES idles all-ones in reset so every pin latch starts cleared
  always_ff @(posedge CLK)
    if (RST) begin
      st_q <= ST_IDLE;
      dat_q <= '0;
      mod_q <= '0;
      sel_q <= '0;
      irqen_q <= '0;
      irqpol_q <= '0;
      irqres_q <= '1;
      irq_q <= 1'b0;
    end else begin
      st_q <= req ? ST_ACK : ST_IDLE;
      dat_q <= req && !WB_WE ? rdata : '0;
      mod_q <= mod_d;
      sel_q <= sel_d;
      irqen_q <= irqen_d;
      irqpol_q <= irqpol_d;
      irqres_q <= wr && word == W_IRQSTAT ? WB_DAT_W[NPINS-1:0] & msk[NPINS-1:0] : '0;
      irq_q <= |(INTR & irqen_q);
    end
endmodule
